// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the round-robin UART TX arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [7:0] HDR_PREFIX = 8'hA0;

  // Minimum width able to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid index searching upward from ptr_i+1, wrapping.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [clog2(NUM_REQ)-1:0] ptr_i,
  input  logic [NUM_REQ-1:0]        valid_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                      any_o
);

  localparam int IW = clog2(NUM_REQ);

  int cand;

  // NOTE: every output gets a default before the search loop, otherwise the
  // paths that find no winner would infer latches.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_o && valid_i[i] && cand == i) begin
          any_o       = 1'b1;
          grant_o[i]  = 1'b1;
          grant_idx_o = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources, with done-timeout.
// Define UART_ARB_HEADER_EN to prefix each data byte with a header frame (8'hA0 | grant_id).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [8*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_en,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [clog2(NUM_REQ)-1:0] grant_id,
  output logic                      timeout_err
);

  localparam int IW = clog2(NUM_REQ);
  localparam int TW = clog2(TIMEOUT_CYCLES);
  localparam int GW = clog2(GAP_CYCLES);

  state_e          state_q, state_d;
  logic [7:0]      buf_q, buf_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic            timeout_q, timeout_d;
`ifdef UART_ARB_HEADER_EN
  logic            pending_q, pending_d;
`endif

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [7:0]         sel_byte;
  logic               timer_max;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .ptr_i      (ptr_q),
    .valid_i    (req_valid),
    .grant_o    (arb_grant),
    .grant_idx_o(arb_idx),
    .any_o      (arb_any)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_byte = req_data[8*i +: 8];
    end
  end

  assign timer_max = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      // NOTE: the byte buffer is reset as well so no stale byte survives a reset.
      buf_q     <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      ptr_q     <= IW'(NUM_REQ - 1);
      gid_q     <= '0;
      timeout_q <= 1'b0;
`ifdef UART_ARB_HEADER_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      timeout_q <= timeout_d;
`ifdef UART_ARB_HEADER_EN
      pending_q <= pending_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    timeout_d = 1'b0;
`ifdef UART_ARB_HEADER_EN
    pending_d = pending_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          buf_d   = sel_byte;
          gid_d   = arb_idx;
          ptr_d   = arb_idx;
          timer_d = '0;
`ifdef UART_ARB_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = ST_SEND;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      ST_HDR: begin
        // A header that times out drops its data byte as well.
        if (tx_done || timer_max) begin
          state_d   = ST_GAP;
          gap_d     = '0;
          timeout_d = !tx_done;
          pending_d = tx_done;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      ST_SEND: begin
        if (tx_done || timer_max) begin
          state_d   = ST_GAP;
          gap_d     = '0;
          timeout_d = !tx_done;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
`ifdef UART_ARB_HEADER_EN
          if (pending_q) begin
            state_d   = ST_SEND;
            timer_d   = '0;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    tx_en     = 1'b0;
    tx_data   = '0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: req_ready = arb_grant;
`ifdef UART_ARB_HEADER_EN
      ST_HDR: begin
        tx_en   = 1'b1;
        tx_data = HDR_PREFIX | 8'(gid_q);
      end
`endif
      ST_SEND: begin
        tx_en   = 1'b1;
        tx_data = buf_q;
      end
      default: ;
    endcase
  end

  assign grant_id    = gid_q;
  assign timeout_err = timeout_q;

endmodule
